mult_div_unit: RTL and testbench

Parametrised multiply/divide unit for the pipelined MIPS core. It sits beside the ALU in the E stage and owns the HI/LO register pair. It executes signed and unsigned multiply and divide over multiple cycles, and supports MTHI/MTLO writes and combinational MFHI/MFLO reads. Compared with the fixed 32-bit unit, it adds generic width and configurable multiply latency, and divides with a true iterative restoring divider. It also adds a precise `cancel` abort for exceptions, a divide-by-zero flag, and optional multiply-accumulate.

---
 rtl/mult_div_unit.sv | 188 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair: iterative restoring divide,
// cancel abort, divide-by-zero flag. Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module mult_div_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int unsigned CMAX  = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int unsigned CNT_W = $clog2(CMAX);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;
    localparam logic [3:0] OP_MADD  = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd11;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   rem;
    logic [3:0]         op_r;
    logic               q_neg;
    logic               r_neg;

    logic               is_mul;
    logic               is_div;
    logic               in_signed;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               mul_signed;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_next;

`ifdef MDU_MADD_EN
    logic [2*WIDTH-1:0] acc;
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op >= OP_MADD && op <= OP_MSUBU);
    assign acc    = op_r[1] ? ({hi, lo} - prod) : ({hi, lo} + prod);
`else
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif

    // Accept-time decode; divides latch operand magnitudes and result signs
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign in_signed = (op == OP_DIV);
    assign a_abs     = (in_signed && a[WIDTH-1]) ? -a : a;
    assign b_abs     = (in_signed && b[WIDTH-1]) ? -b : b;

    // Full-width product from the latched operands
    assign mul_signed = (op_r == OP_MULT) || (op_r == OP_MADD) || (op_r == OP_MSUB);
    assign ext_a      = {{WIDTH{a_r[WIDTH-1] & mul_signed}}, a_r};
    assign ext_b      = {{WIDTH{b_r[WIDTH-1] & mul_signed}}, b_r};
    assign prod       = ext_a * ext_b;

    // One restoring-division step: a_r shifts out dividend bits and in quotient bits
    assign shifted  = {rem, a_r[WIDTH-1]};
    assign ge       = shifted >= {1'b0, b_r};
    assign diff     = shifted - {1'b0, b_r};
    assign rem_next = ge ? WIDTH'(diff) : WIDTH'(shifted);

    always_comb begin
        dout = '0;
        if (op == OP_MFHI)
            dout = hi;
        else if (op == OP_MFLO)
            dout = lo;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            cnt      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            rem      <= '0;
            op_r     <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            busy     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        if (is_mul) begin
                            a_r   <= a;
                            b_r   <= b;
                            op_r  <= op;
                            cnt   <= CNT_W'(MUL_LAT - 1);
                            busy  <= 1'b1;
                            state <= MUL;
                        end else if (is_div) begin
                            a_r   <= a_abs;
                            b_r   <= b_abs;
                            op_r  <= op;
                            rem   <= '0;
                            q_neg <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg <= in_signed && a[WIDTH-1];
                            cnt   <= CNT_W'(WIDTH - 1);
                            busy  <= 1'b1;
                            state <= DIV;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                MUL: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
`ifdef MDU_MADD_EN
                        if (op_r[3])
                            {hi, lo} <= acc;
                        else
                            {hi, lo} <= prod;
`else
                        {hi, lo} <= prod;
`endif
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rem <= rem_next;
                        a_r <= {a_r[WIDTH-2:0], ge};
                        if (cnt == '0)
                            state <= FIX;
                        else
                            cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        if (b_r == '0) begin
                            div_zero <= 1'b1;
                        end else begin
                            lo <= q_neg ? -a_r : a_r;
                            hi <= r_neg ? -rem : rem;
                        end
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32, MUL_LAT=5): vector table plus
// hand sequences for cancel, back-to-back, hazards and async reset.
module tb_mult_div_unit;
    localparam logic [3:0] MULT = 4'd0, MULTU = 4'd1, DIV = 4'd2, DIVU = 4'd3;
    localparam logic [3:0] MFHI = 4'd4, MFLO = 4'd5, MTHI = 4'd6, MTLO = 4'd7;
    localparam logic [3:0] MADD = 4'd8, MSUBU = 4'd11, NOP = 4'd12;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd12;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] dout;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int checks = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(32), .MUL_LAT(5)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .dout(dout), .hi(hi), .lo(lo),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
        int          dz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op from a falling edge; returns busy-cycle count and div_zero pulse count
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int dzc);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = NOP;
        lat = 0; dzc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (div_zero) dzc++;
            if (!busy) break;
            lat++;
        end
        @(negedge clk);
        if (div_zero) dzc++;
    endtask

    initial begin
        int lat, dzc;
        vecs[0]  = '{MULT,  32'hFFFFFFFE, 32'h3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 0};
        vecs[1]  = '{MULTU, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h0, 32'h00000002, 32'hFFFFFFFA, 5, 0};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0};
        vecs[3]  = '{DIVU,  32'h7, 32'h0, 32'h11, 32'h22, 32'h11, 32'h22, 33, 1};
        vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h0, 32'h80000000, 33, 0};
        vecs[5]  = '{DIVU,  32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 33, 0};
        vecs[6]  = '{DIV,   32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'd1, 32'hFFFFFFFD, 33, 0};
        vecs[7]  = '{MULT,  32'd5, 32'd5, 32'h9, 32'h9, 32'h0, 32'd25, 5, 0};
        vecs[8]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h1, 5, 0};
        vecs[9]  = '{DIV,   32'd5, 32'h0, 32'hAB, 32'hCD, 32'hAB, 32'hCD, 33, 1};
`ifdef MDU_MADD_EN
        vecs[10] = '{MADD,  32'd2, 32'd3, 32'h0, 32'h1, 32'h0, 32'h7, 5, 0};
        vecs[11] = '{MSUBU, 32'd1, 32'd8, 32'h0, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0};
`else
        vecs[10] = '{MADD,  32'd2, 32'd3, 32'h0, 32'h1, 32'h0, 32'h1, 0, 0};
        vecs[11] = '{MSUBU, 32'd1, 32'd8, 32'h0, 32'h7, 32'h0, 32'h7, 0, 0};
`endif

        // Reset state
        #2;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_dz", 32'(div_zero), 32'h0);
        check("rst_dout", dout, 32'h0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_op(MTHI, vecs[i].pre_hi, 32'h0, lat, dzc);
            do_op(MTLO, vecs[i].pre_lo, 32'h0, lat, dzc);
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, dzc);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            check($sformatf("v%0d_dz", i), 32'(dzc), 32'(vecs[i].dz));
        end

        // MTHI/MTLO, dout mux, then MULT cancelled in its 3rd busy cycle
        do_op(MTHI, 32'h12345678, 32'h0, lat, dzc);
        do_op(MTLO, 32'h9ABCDEF0, 32'h0, lat, dzc);
        op = MFHI; #1 check("dout_hi", dout, 32'h12345678);
        op = MFLO; #1 check("dout_lo", dout, 32'h9ABCDEF0);
        op = MULT; #1 check("dout_other", dout, 32'h0);
        op = NOP;
        @(negedge clk);
        op = MULT; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; op = NOP;
        repeat (3) @(negedge clk);
        check("cxl_busy_before", 32'(busy), 32'h1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cxl_busy_after", 32'(busy), 32'h0);
        repeat (6) @(negedge clk);
        check("cxl_hi", hi, 32'h12345678);
        check("cxl_lo", lo, 32'h9ABCDEF0);

        // Start together with cancel in IDLE is not accepted
        op = MULT; a = 32'd2; b = 32'd2; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1 start = 1'b0; cancel = 1'b0; op = NOP;
        @(negedge clk);
        check("idle_cxl_busy", 32'(busy), 32'h0);

        // MTHI while busy is ignored
        op = MULT; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        op = MTHI; a = 32'hDEADBEEF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; op = NOP;
        repeat (6) @(negedge clk);
        check("mt_busy_hi", hi, 32'h0);
        check("mt_busy_lo", lo, 32'd42);

        // Back-to-back: MULT accepted in the cycle after MULTU's busy falls
        do_op(MULTU, 32'hFFFFFFFE, 32'h3, lat, dzc);
        op = MULT; a = 32'hFFFFFFFE; b = 32'h3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; op = NOP;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        op = MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; op = NOP;
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'h1);
        check("b2b_prev_hi", hi, 32'hFFFFFFFF);
        repeat (6) @(negedge clk);
        check("b2b_lo", lo, 32'd12);

        // Cancel on the completion edge of a divide by zero suppresses div_zero
        op = DIVU; a = 32'd9; b = 32'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; op = NOP;
        repeat (33) @(negedge clk);
        check("cxl_dz_busy", 32'(busy), 32'h1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cxl_dz_flag", 32'(div_zero), 32'h0);
        check("cxl_dz_busy_after", 32'(busy), 32'h0);

        // Async reset mid-divide clears state before the next clock edge
        @(negedge clk);
        op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; op = NOP;
        repeat (10) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_busy", 32'(busy), 32'h0);
        check("clr_hi", hi, 32'h0);
        check("clr_lo", lo, 32'h0);
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        check("clr_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
